// File: rtl/obstacle_scheduler_if.sv
// obstacle_scheduler_if: game-state inputs and obstacle-slot outputs of the obstacle scheduler
interface obstacle_scheduler_if;
    logic        frame_tick;
    logic [1:0]  gamestate;
    logic [3:0]  speed;
    logic [13:0] score;
    logic [9:0]  ObstacleX;
    logic [9:0]  ObstacleY;
    logic [3:0]  ObstacleSEL;
    logic        BirdSEL;
    logic        obstacle_valid;
    logic        obstacle_passed;
    modport master (
        output frame_tick, gamestate, speed, score,
        input  ObstacleX, ObstacleY, ObstacleSEL, BirdSEL, obstacle_valid, obstacle_passed
    );
    modport slave (
        input  frame_tick, gamestate, speed, score,
        output ObstacleX, ObstacleY, ObstacleSEL, BirdSEL, obstacle_valid, obstacle_passed
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: spawns, scrolls and retires the single obstacle slot with LFSR-randomized type and gap
module obstacle_scheduler #(
    parameter logic [9:0]  SPAWN_X    = 10'd640,
    parameter logic [9:0]  DINO_X     = 10'd60,
    parameter logic [9:0]  GROUND_Y   = 10'd380,
    parameter logic [9:0]  BIRD_Y_HI  = 10'd180,
    parameter logic [9:0]  BIRD_Y_LO  = 10'd230,
    parameter logic [6:0]  GAP_MIN    = 7'd40,
    parameter logic [6:0]  GAP_STEP   = 7'd4,
    parameter logic [13:0] BIRD_SCORE = 14'd200,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic clk,
    input logic rst,
    obstacle_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GAP, ACTIVE, FROZEN} state_t;
    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [3:0]  sel_q, sel_d;
    logic        bird_q, bird_d, valid_q, valid_d, passed_q, passed_d, flag_q, flag_d;
    logic [6:0]  gap_q, gap_d, next_gap_q, next_gap_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  gs;
    logic [9:0]  s, x_dec, y_new;
    logic [3:0]  sel_new;
    logic [2:0]  t;
    logic        bird, retire;
    always_comb begin
        gs      = bus.gamestate == 2'b11 ? 2'b00 : bus.gamestate;
        s       = bus.speed == 4'd0 ? 10'd1 : {6'd0, bus.speed};
        x_dec   = x_q - s;
        retire  = x_q <= s;
        t       = lfsr_q[2:0];
        bird    = t[2] & t[1] & (bus.score >= BIRD_SCORE);
        sel_new = bird ? 4'b1000 : (t == 3'd2 || t[2:1] == 2'b11) ? 4'b0101 :
                  t == 3'd3 ? 4'b0110 : t == 3'd4 ? 4'b0111 : 4'b0100;
        // odd cactus codes are the big (taller) variants
        y_new   = bird ? (lfsr_q[3] ? BIRD_Y_HI : BIRD_Y_LO) :
                  sel_new[0] ? GROUND_Y - 10'd100 : GROUND_Y - 10'd70;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        sel_d = sel_q;
        bird_d = bird_q;
        valid_d = valid_q;
        passed_d = 1'b0;
        flag_d = flag_q;
        gap_d = gap_q;
        next_gap_d = next_gap_q;
        if (gs == 2'b00) begin
            state_d = IDLE;
            valid_d = 1'b0;
            x_d = SPAWN_X;
            gap_d = GAP_MIN;
            flag_d = 1'b0;
        end else if (state_q == IDLE) begin
            gap_d = GAP_MIN;
            state_d = gs == 2'b01 ? GAP : IDLE;
        end else if (state_q == FROZEN) begin
            if (gs == 2'b01) begin
                state_d = GAP;
                valid_d = 1'b0;
                x_d = SPAWN_X;
                gap_d = GAP_MIN;
                flag_d = 1'b0;
            end
        end else if (gs == 2'b10) begin
            state_d = FROZEN;
        end else if (bus.frame_tick && state_q == GAP) begin
            if (gap_q == 7'd1) begin
                state_d = ACTIVE;
                x_d = SPAWN_X;
                y_d = y_new;
                sel_d = sel_new;
                bird_d = bird & lfsr_q[3];
                valid_d = 1'b1;
                flag_d = 1'b0;
                next_gap_d = GAP_MIN + {3'd0, lfsr_q[7:4]} * GAP_STEP;
            end else begin
                gap_d = gap_q - 7'd1;
            end
        end else if (bus.frame_tick) begin
            // a retiring obstacle has necessarily left the dino behind
            if (!flag_q && (retire || x_dec < DINO_X)) begin
                passed_d = 1'b1;
                flag_d = 1'b1;
            end
            if (retire) begin
                state_d = GAP;
                valid_d = 1'b0;
                x_d = SPAWN_X;
                gap_d = next_gap_q;
            end else begin
                x_d = x_dec;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q <= SPAWN_X;
            y_q <= GROUND_Y - 10'd70;
            sel_q <= 4'b0100;
            bird_q <= 1'b0;
            valid_q <= 1'b0;
            passed_q <= 1'b0;
            flag_q <= 1'b0;
            gap_q <= GAP_MIN;
            next_gap_q <= GAP_MIN;
            lfsr_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            sel_q <= sel_d;
            bird_q <= bird_d;
            valid_q <= valid_d;
            passed_q <= passed_d;
            flag_q <= flag_d;
            gap_q <= gap_d;
            next_gap_q <= next_gap_d;
            lfsr_q <= lfsr_d;
        end
    end
    assign bus.ObstacleX = x_q;
    assign bus.ObstacleY = y_q;
    assign bus.ObstacleSEL = sel_q;
    assign bus.BirdSEL = bird_q;
    assign bus.obstacle_valid = valid_q;
    assign bus.obstacle_passed = passed_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed bench with a spawn scoreboard and a reference LFSR
module tb_obstacle_scheduler;
    typedef struct packed {
        logic [3:0] sel;
        logic [9:0] y;
        logic       b;
        logic       is_bird;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] m_lfsr;
    exp_t sb[$];
    exp_t last_e;
    int n_cmp = 0;
    int n_err = 0;
    int exp_gap = 40;
    int pulses;
    int k;
    logic [9:0] px;
    always #5 clk = ~clk;
    obstacle_scheduler_if bus();
    obstacle_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
    always @(posedge clk)
        m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask
    function automatic exp_t predict(input logic [15:0] l, input logic [13:0] sc);
        exp_t e;
        e.is_bird = (l[2:0] >= 3'd6) && (sc >= 14'd200);
        case (l[2:0])
            3'd2: e.sel = 4'b0101;
            3'd3: e.sel = 4'b0110;
            3'd4: e.sel = 4'b0111;
            3'd6, 3'd7: e.sel = e.is_bird ? 4'b1000 : 4'b0101;
            default: e.sel = 4'b0100;
        endcase
        e.b = e.is_bird & l[3];
        e.y = e.is_bird ? (l[3] ? 10'd180 : 10'd230) :
              (e.sel == 4'b0101 || e.sel == 4'b0111) ? 10'd280 : 10'd310;
        return e;
    endfunction
    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask
    task automatic wait_lfsr(input logic [15:0] mask, input logic [15:0] val);
        int i = 0;
        while ((m_lfsr & mask) !== val && i < 5000) begin
            @(negedge clk);
            i++;
        end
        chk("lfsr_wait", m_lfsr & mask, val);
    endtask
    task automatic spawn(input int n, input logic [15:0] mask, input logic [15:0] val);
        exp_t e;
        int g;
        for (int i = 0; i < n - 1; i++) tick();
        chk("pre_spawn_valid", bus.obstacle_valid, 0);
        if (mask != 16'd0) wait_lfsr(mask, val);
        sb.push_back(predict(m_lfsr, bus.score));
        g = 40 + int'(m_lfsr[7:4]) * 4;
        tick();
        chk("spawn_valid", bus.obstacle_valid, 1);
        chk("spawn_x", bus.ObstacleX, 640);
        chk("sb_depth", sb.size(), 1);
        e = sb.pop_front();
        chk("spawn_sel", bus.ObstacleSEL, e.sel);
        chk("spawn_y", bus.ObstacleY, e.y);
        if (e.is_bird) chk("spawn_birdsel", bus.BirdSEL, e.b);
        last_e = e;
        exp_gap = g;
    endtask
    initial begin
        bus.frame_tick = 1'b0;
        bus.gamestate = 2'b01;
        bus.speed = 4'd5;
        bus.score = 14'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", bus.obstacle_valid, 0);
        chk("rst_x", bus.ObstacleX, 640);
        chk("rst_y", bus.ObstacleY, 310);
        chk("rst_sel", bus.ObstacleSEL, 4'b0100);
        chk("rst_passed", bus.obstacle_passed, 0);
        chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst = 1'b0;
        @(negedge clk);
        spawn(40, 16'h0007, 16'h0003);
        chk("cac2s_sel", bus.ObstacleSEL, 4'b0110);
        chk("cac2s_y", bus.ObstacleY, 310);
        for (int i = 0; i < 10; i++) tick();
        chk("scroll_x", bus.ObstacleX, 590);
        pulses = 0;
        px = 10'd0;
        k = 0;
        while (bus.ObstacleX != 10'd5 && k < 200) begin
            tick();
            k++;
            if (bus.obstacle_passed) begin
                pulses++;
                px = bus.ObstacleX;
            end
        end
        chk("reach_x5", bus.ObstacleX, 5);
        chk("pass_count", pulses, 1);
        chk("pass_x", px, 55);
        tick();
        chk("retire_valid", bus.obstacle_valid, 0);
        chk("retire_x", bus.ObstacleX, 640);
        chk("retire_passed", bus.obstacle_passed, 0);
        bus.score = 14'd250;
        spawn(exp_gap, 16'h000F, 16'h000E);
        chk("bird_sel", bus.ObstacleSEL, 4'b1000);
        chk("bird_hi", bus.BirdSEL, 1);
        chk("bird_y", bus.ObstacleY, 180);
        bus.gamestate = 2'b00;
        @(negedge clk);
        chk("idle_valid", bus.obstacle_valid, 0);
        bus.gamestate = 2'b01;
        @(negedge clk);
        bus.score = 14'd150;
        spawn(40, 16'h000F, 16'h000E);
        chk("nobird_sel", bus.ObstacleSEL, 4'b0101);
        chk("nobird_y", bus.ObstacleY, 280);
        bus.speed = 4'd0;
        tick();
        chk("speed0_a", bus.ObstacleX, 639);
        tick();
        chk("speed0_b", bus.ObstacleX, 638);
        pulses = 0;
        k = 0;
        while (bus.ObstacleX != 10'd12 && k < 1000) begin
            bus.speed = (bus.ObstacleX - 10'd12 > 10'd15) ? 4'd15 : 4'(bus.ObstacleX - 10'd12);
            tick();
            k++;
            if (bus.obstacle_passed) pulses++;
        end
        chk("reach_x12", bus.ObstacleX, 12);
        chk("descent_pass_count", pulses, 1);
        bus.speed = 4'd15;
        tick();
        chk("fast_retire_valid", bus.obstacle_valid, 0);
        chk("fast_retire_x", bus.ObstacleX, 640);
        chk("fast_retire_passed", bus.obstacle_passed, 0);
        spawn(exp_gap, 16'h0, 16'h0);
        bus.speed = 4'd10;
        for (int i = 0; i < 34; i++) tick();
        chk("pre_freeze_x", bus.ObstacleX, 300);
        bus.gamestate = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("frozen_x", bus.ObstacleX, 300);
            chk("frozen_sel", bus.ObstacleSEL, last_e.sel);
            chk("frozen_valid", bus.obstacle_valid, 1);
            chk("frozen_passed", bus.obstacle_passed, 0);
        end
        bus.gamestate = 2'b01;
        @(negedge clk);
        chk("restart_valid", bus.obstacle_valid, 0);
        spawn(40, 16'h0, 16'h0);
        bus.speed = 4'd10;
        for (int i = 0; i < 58; i++) tick();
        chk("pre_rst_x", bus.ObstacleX, 60);
        rst = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("rst2_valid", bus.obstacle_valid, 0);
        chk("rst2_x", bus.ObstacleX, 640);
        chk("rst2_y", bus.ObstacleY, 310);
        chk("rst2_sel", bus.ObstacleSEL, 4'b0100);
        chk("rst2_birdsel", bus.BirdSEL, 0);
        chk("rst2_passed", bus.obstacle_passed, 0);
        rst = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
